uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter.
// Sends one frame per accepted request: a start bit, DBIT data bits LSB first,
// an optional parity bit, and a stop period. Bit timing comes from s_tick, a
// one-clk enable pulse at 16x the baud rate. Each data, start and parity bit
// lasts 16 ticks, and the stop period lasts SB_TICK ticks.
module uart_tx #(
  parameter int DBIT       = 8,   // data bits per frame, 5..8
  parameter int SB_TICK    = 16,  // ticks in the stop period, 16..32
  parameter int PARITY_EN  = 0,   // 1 = append a parity bit after the data
  parameter int PARITY_ODD = 0    // 1 = odd parity, 0 = even parity
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Last tick index of a 16-tick bit, of the stop period, and last data bit.
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  // Only din[DBIT-1:0] takes part in the parity calculation.
  localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD != 0);
  localparam logic       PAR_ON    = (PARITY_EN != 0);

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;      // tick counter within the current bit
  logic [2:0] n_q, n_d;      // data bit index
  logic [7:0] b_q, b_d;      // shift register; b_q[0] is on the line
  logic       par_q, par_d;  // parity bit captured at acceptance
  logic       tx_q, tx_d;    // registered serial output
  logic       done_d;        // end of stop period, this clk only

  // Next-state and datapath updates; counters move only on s_tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // s_tick in the accept clk is deliberately not counted.
        if (tx_start) begin
          b_d     = din;
          par_d   = (^(din & DATA_MASK)) ^ ODD_SEL;
          s_d     = 5'd0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = 5'd0;
            n_d     = 3'd0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = 5'd0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered, so tx and state change together.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces an idle, high line at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= 5'd0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  // A reset in the final stop clk suppresses the done pulse.
  assign tx_done_tick = done_d & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations share clk, reset,
// s_tick and din; sel routes tx_start to one of them and picks its outputs.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] din = 8'h00;
  int         sel = 0;

  logic txv [4];
  logic busyv [4];
  logic donev [4];
  logic startv [4];

  logic obs_tx, obs_busy, obs_done;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  // s_tick: one clk high every 4 clks, changed on the falling edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      s_tick = (div == 0);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) startv[i] = tx_start && (sel == i);
    obs_tx   = txv[sel];
    obs_busy = busyv[sel];
    obs_done = donev[sel];
  end

  uart_tx u_8n1 (
    .clk(clk), .reset(reset), .tx_start(startv[0]), .s_tick(s_tick), .din(din),
    .tx(txv[0]), .tx_done_tick(donev[0]), .tx_busy(busyv[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .reset(reset), .tx_start(startv[1]), .s_tick(s_tick), .din(din),
    .tx(txv[1]), .tx_done_tick(donev[1]), .tx_busy(busyv[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_start(startv[2]), .s_tick(s_tick), .din(din),
    .tx(txv[2]), .tx_done_tick(donev[2]), .tx_busy(busyv[2]));

  uart_tx #(.DBIT(7), .SB_TICK(32)) u_7n2 (
    .clk(clk), .reset(reset), .tx_start(startv[3]), .s_tick(s_tick), .din(din),
    .tx(txv[3]), .tx_done_tick(donev[3]), .tx_busy(busyv[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push the expected line levels of one frame: start, data LSB first, parity, stop.
  task automatic push_frame(input logic [7:0] d, input int dbit, input bit pe, input bit odd);
    logic [7:0] m;
    logic p;
    m = d & 8'((1 << dbit) - 1);
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dbit; i++) begin
      exp_q.push_back(m[i]);
      p = p ^ m[i];
    end
    if (pe) exp_q.push_back(p ^ odd);
    exp_q.push_back(1'b1);
  endtask

  // Request a frame and check the line drops on the accepting edge.
  task automatic send(input logic [7:0] d, input int dbit, input bit pe, input bit odd,
                      input bit hold);
    push_frame(d, dbit, pe, odd);
    @(negedge clk);
    din = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("start_edge[%0d]", sel), {31'd0, obs_tx}, 32'd0);
    chk($sformatf("busy_at_start[%0d]", sel), {31'd0, obs_busy}, 32'd1);
    if (!hold) tx_start = 1'b0;
  endtask

  // Follow one frame tick by tick: sample each bit mid-way against the
  // scoreboard, count ticks until idle and count done pulses. inj_tick
  // pulses tx_start with din=3C; rst_tick aborts the frame with reset.
  task automatic run_frame(input int nb, input int sb, input int inj_tick, input int rst_tick);
    int  ticks, dones, cyc, next_sample, samples;
    bit  ended, inj_armed, inj_done;
    logic e;
    ticks = 0; dones = 0; cyc = 0; next_sample = 8; samples = 0;
    ended = 0; inj_armed = 0; inj_done = 0;
    while (!ended && cyc < 4 * (16 * nb + sb) + 64) begin
      @(posedge clk);
      if (s_tick) ticks++;
      #1;
      cyc++;
      if (inj_armed) begin
        tx_start = 1'b0;
        inj_armed = 0;
      end
      if (ticks == rst_tick) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, obs_tx}, 32'd1);
        chk("reset_busy", {31'd0, obs_busy}, 32'd0);
        chk("reset_done", {31'd0, obs_done}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (ticks == inj_tick && !inj_done) begin
        din = 8'h3C;
        tx_start = 1'b1;
        inj_armed = 1;
        inj_done = 1;
      end
      if (ticks == next_sample && samples < nb + 1) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bit%0d[%0d]", samples, sel), {31'd0, obs_tx}, {31'd0, e});
        end
        samples++;
        next_sample += 16;
      end
      if (obs_done === 1'b1) dones++;
      if (obs_busy === 1'b0) ended = 1;
    end
    chk($sformatf("frame_ended[%0d]", sel), {31'd0, ended}, 32'd1);
    chk($sformatf("frame_ticks[%0d]", sel), ticks, 16 * nb + sb);
    chk($sformatf("done_pulses[%0d]", sel), dones, 32'd1);
    chk($sformatf("samples[%0d]", sel), samples, nb + 1);
    chk($sformatf("idle_tx[%0d]", sel), {31'd0, obs_tx}, 32'd1);
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    int bad;

    // Reset state of every instance.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      chk($sformatf("rst_tx[%0d]", i), {31'd0, obs_tx}, 32'd1);
      chk($sformatf("rst_busy[%0d]", i), {31'd0, obs_busy}, 32'd0);
      chk($sformatf("rst_done[%0d]", i), {31'd0, obs_done}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_clks(3);

    // 8N1, A5.
    sel = 0;
    send(8'hA5, 8, 0, 0, 0);
    run_frame(9, 16, -1, -1);
    idle_clks(5);

    // Even parity: 07 -> 1, 03 -> 0.
    sel = 1;
    send(8'h07, 8, 1, 0, 0);
    run_frame(10, 16, -1, -1);
    idle_clks(3);
    send(8'h03, 8, 1, 0, 0);
    run_frame(10, 16, -1, -1);
    idle_clks(3);

    // Odd parity: 07 -> 0.
    sel = 2;
    send(8'h07, 8, 1, 1, 0);
    run_frame(10, 16, -1, -1);
    idle_clks(3);

    // Request with 3C during data bit 2 is ignored; no second frame follows.
    sel = 0;
    send(8'hA5, 8, 0, 0, 0);
    run_frame(9, 16, 16 * 3 + 4, -1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) bad++;
    end
    chk("no_second_frame", bad, 32'd0);

    // Reset in the middle of data bit 3, then a clean 5A frame.
    send(8'hA5, 8, 0, 0, 0);
    run_frame(9, 16, -1, 16 * 4 + 5);
    idle_clks(3);
    send(8'h5A, 8, 0, 0, 0);
    run_frame(9, 16, -1, -1);
    idle_clks(3);

    // tx_start held: FF then 00 back to back with one idle clk between.
    send(8'hFF, 8, 0, 0, 1);
    din = 8'h00;
    push_frame(8'h00, 8, 0, 0);
    run_frame(9, 16, -1, -1);
    @(posedge clk);
    #1;
    chk("b2b_second_start_tx", {31'd0, obs_tx}, 32'd0);
    chk("b2b_second_start_busy", {31'd0, obs_busy}, 32'd1);
    tx_start = 1'b0;
    run_frame(9, 16, -1, -1);
    idle_clks(3);

    // DBIT=7, two stop bits: din[7] is not sent.
    sel = 3;
    send(8'h80, 7, 0, 0, 0);
    run_frame(8, 32, -1, -1);
    idle_clks(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
